md_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core.
- Sits directly downstream of the GPR read ports. It consumes the rs/rt read data and produces HI/LO, which the writeback mux selects for MFHI/MFLO.
- Asserts md_busy while an operation runs; control uses it to stall the PC.

---
 rtl/ctrl_encode_def.sv | 23 ++
 rtl/md_iter_core.sv | 64 ++++++
 rtl/md_unit.sv | 125 ++++++++++++
 tb/tb_md_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_encode_def.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, helpers.
// Pure definitions; no timing or flow control of its own.
package ctrl_encode_def;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV_S = 2'b10,
        MD_FIX  = 2'b11
    } md_state_t;

    function automatic logic [31:0] md_abs(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iteration counter plus 64-bit shift datapath (shift-add multiply / restoring divide).
// One step per cycle while run is high; load restarts it. No backpressure.
module md_iter_core #(
    parameter int ITER = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                run,
    input  logic                mode_div,
    input  logic [ITER-1:0]     a_in,
    input  logic [ITER-1:0]     b_in,
    output logic [2*ITER-1:0]   acc,
    output logic                last
);

    localparam int CW = $clog2(ITER) + 1;

    logic [CW-1:0]     cnt;
    logic [ITER-1:0]   b_q;
    logic              div_q;
    logic [ITER:0]     add_sum;
    logic [ITER:0]     sub_diff;
    logic [2*ITER-1:0] acc_nxt;

    // Multiply keeps the multiplier in the low half and shifts the product in from the top;
    // divide keeps the partial remainder on top and shifts quotient bits in at the bottom.
    always_comb begin
        add_sum  = {1'b0, acc[2*ITER-1:ITER]} + {1'b0, b_q};
        sub_diff = acc[2*ITER-1:ITER-1] - {1'b0, b_q};
        acc_nxt  = acc;
        if (div_q) begin
            if (sub_diff[ITER])
                acc_nxt = {acc[2*ITER-2:0], 1'b0};
            else
                acc_nxt = {sub_diff[ITER-1:0], acc[ITER-2:0], 1'b1};
        end else begin
            if (acc[0])
                acc_nxt = {add_sum, acc[ITER-1:1]};
            else
                acc_nxt = {1'b0, acc[2*ITER-1:1]};
        end
    end

    assign last = (cnt == CW'(ITER - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            acc   <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            cnt   <= '0;
            acc   <= {{ITER{1'b0}}, a_in};
            b_q   <= b_in;
            div_q <= mode_div;
        end else if (run) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/md_unit.sv
// Iterative mult/div with HI/LO; busy for ITER+1 cycles after accept, done pulses on HI/LO write.
// Starts are ignored while busy; control holds the instruction until md_busy drops.
module md_unit
    import ctrl_encode_def::*;
#(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic [31:0] md_rs,
    input  logic [31:0] md_rt,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] md_hi,
    output logic [31:0] md_lo
);

    md_state_t   state;
    logic        neg_res_q;
    logic        neg_rem_q;
    logic        div0_q;
    logic        op_div_q;
    logic [31:0] rs_q;

    logic        is_signed;
    logic        accept_md;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] acc;
    logic        core_last;
    logic        core_run;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    assign is_signed = ~md_op[0];
    assign accept_md = (state == MD_IDLE) && md_start && !md_op[2];
    assign a_mag     = is_signed ? md_abs(md_rs) : md_rs;
    assign b_mag     = is_signed ? md_abs(md_rt) : md_rt;
    assign core_run  = (state == MD_MUL) || (state == MD_DIV_S);

    md_iter_core #(.ITER(ITER)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept_md),
        .run      (core_run),
        .mode_div (md_op[1]),
        .a_in     (a_mag),
        .b_in     (b_mag),
        .acc      (acc),
        .last     (core_last)
    );

    // Divide-by-zero bypasses sign correction and returns the raw dividend in HI.
    always_comb begin
        prod_fix = neg_res_q ? (~acc + 64'd1) : acc;
        quo_fix  = neg_res_q ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = neg_rem_q ? (~acc[63:32] + 32'd1) : acc[63:32];
        fix_hi   = prod_fix[63:32];
        fix_lo   = prod_fix[31:0];
        if (op_div_q) begin
            if (div0_q) begin
                fix_hi = rs_q;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_hi = rem_fix;
                fix_lo = quo_fix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= MD_IDLE;
            md_hi     <= '0;
            md_lo     <= '0;
            md_busy   <= 1'b0;
            md_done   <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            op_div_q  <= 1'b0;
            rs_q      <= '0;
        end else begin
            md_done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (md_start) begin
                        case (md_op)
                            MD_MTHI: md_hi <= md_rs;
                            MD_MTLO: md_lo <= md_rs;
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                state     <= md_op[1] ? MD_DIV_S : MD_MUL;
                                md_busy   <= 1'b1;
                                neg_res_q <= is_signed & (md_rs[31] ^ md_rt[31]);
                                neg_rem_q <= is_signed & md_rs[31];
                                div0_q    <= (md_rt == 32'd0);
                                op_div_q  <= md_op[1];
                                rs_q      <= md_rs;
                            end
                            default: ;
                        endcase
                    end
                end
                MD_MUL, MD_DIV_S: begin
                    if (core_last)
                        state <= MD_FIX;
                end
                MD_FIX: begin
                    md_hi   <= fix_hi;
                    md_lo   <= fix_lo;
                    md_busy <= 1'b0;
                    md_done <= 1'b1;
                    state   <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: arithmetic results, 33-cycle latency, ignore-while-busy, reset abort.
module tb_md_unit;
    import ctrl_encode_def::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        md_start = 1'b0;
    logic [2:0]  md_op = 3'b000;
    logic [31:0] md_rs = '0;
    logic [31:0] md_rt = '0;
    logic        md_busy;
    logic        md_done;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int acc_cyc   = 0;
    int ncyc;
    logic busy_drop;

    md_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_start (md_start),
        .md_op    (md_op),
        .md_rs    (md_rs),
        .md_rt    (md_rt),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .md_hi    (md_hi),
        .md_lo    (md_lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        md_start = 1'b1;
        md_op    = op;
        md_rs    = rs;
        md_rt    = rt;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        md_start = 1'b0;
        md_rs    = 32'hDEAD_BEEF;
        md_rt    = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done(output int n, output logic dropped);
        dropped = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (md_done) break;
            if (!md_busy) dropped = 1'b1;
        end
        n = cyc - acc_cyc;
    endtask

    task automatic run_check(input string tag, input logic [2:0] op, input logic [31:0] rs,
                             input logic [31:0] rt, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
        issue(op, rs, rt);
        check({tag, "_busy_on"}, {31'd0, md_busy}, 32'd1);
        wait_done(ncyc, busy_drop);
        check({tag, "_latency"}, ncyc, 32'd33);
        check({tag, "_busy_held"}, {31'd0, busy_drop}, 32'd0);
        check({tag, "_busy_off"}, {31'd0, md_busy}, 32'd0);
        check({tag, "_hi"}, md_hi, exp_hi);
        check({tag, "_lo"}, md_lo, exp_lo);
        @(posedge clk);
        #1;
        check({tag, "_done_once"}, {31'd0, md_done}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, md_busy}, 32'd0);
        check("rst_done", {31'd0, md_done}, 32'd0);
        check("rst_hi", md_hi, 32'd0);
        check("rst_lo", md_lo, 32'd0);
        rst_n = 1'b1;

        run_check("mult",   MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_check("multu",  MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_check("div",    MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_check("divu",   MD_DIVU,  32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC);
        run_check("divu0",  MD_DIVU,  32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF);
        run_check("div0s",  MD_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_check("div_ov", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // Starts issued while busy must not disturb HI or the running multiply.
        issue(MD_MULT, 32'd5, 32'd5);
        @(negedge clk);
        md_start = 1'b1;
        md_op    = MD_MTHI;
        md_rs    = 32'h0000_1234;
        @(posedge clk);
        #1;
        check("busy_mthi_hi", md_hi, 32'h0000_0000);
        md_op = MD_DIV;
        md_rs = 32'd9;
        md_rt = 32'd3;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        wait_done(ncyc, busy_drop);
        check("ign_latency", ncyc, 32'd33);
        check("ign_hi", md_hi, 32'd0);
        check("ign_lo", md_lo, 32'd25);

        issue(MD_MTLO, 32'h0000_ABCD, 32'd0);
        check("mtlo_lo", md_lo, 32'h0000_ABCD);
        check("mtlo_hi", md_hi, 32'd0);
        check("mtlo_busy", {31'd0, md_busy}, 32'd0);
        check("mtlo_done", {31'd0, md_done}, 32'd0);
        @(posedge clk);
        #1;
        check("mtlo_done_next", {31'd0, md_done}, 32'd0);

        issue(3'b110, 32'h5555_5555, 32'd1);
        check("rsv6_busy", {31'd0, md_busy}, 32'd0);
        issue(3'b111, 32'h5555_5555, 32'd1);
        @(posedge clk);
        #1;
        check("rsv_hi", md_hi, 32'd0);
        check("rsv_lo", md_lo, 32'h0000_ABCD);
        check("rsv_busy", {31'd0, md_busy}, 32'd0);

        // Reset in busy cycle 10 aborts with no HI/LO write.
        issue(MD_MTHI, 32'h0000_7777, 32'd0);
        issue(MD_MULT, 32'd5, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, md_busy}, 32'd0);
        check("abort_done", {31'd0, md_done}, 32'd0);
        check("abort_hi", md_hi, 32'd0);
        check("abort_lo", md_lo, 32'd0);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (md_done) break;
        end
        check("abort_no_done", {31'd0, md_done}, 32'd0);
        check("abort_lo_hold", md_lo, 32'd0);

        run_check("post_rst", MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
